// File: rtl/rca_slice.sv
// Combinational ripple-carry slice: SLICE-bit add with carry in, carry out,
// and the carry into the slice MSB (used by the top slice for signed overflow).
module rca_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] c;

  // NOTE: blocking assignments in always_comb; the carry chain is read in
  // program order within one evaluation, and every output gets a default.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout  = c[SLICE];
    c_msb = c[SLICE-1];
  end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit adder split into STAGES ripple slices with a registered carry
// between slices; valid/ready handshake with a single global advance enable.
module pipelined_ripple_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;

  // Stage k register holds the operands still to be added, the sum bits
  // completed so far, and the carry out of slice k.
  logic             vld_q   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             c_q     [STAGES];
  logic             ovf_q   [STAGES];

  logic             vld_src [STAGES];
  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [WIDTH-1:0] sum_src [STAGES];
  logic             c_src   [STAGES];
  logic [WIDTH-1:0] sum_nxt [STAGES];
  logic             c_nxt   [STAGES];
  logic             ovf_nxt [STAGES];

  logic adv;

  assign adv       = ~vld_q[STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_first
      assign vld_src[k] = in_valid;
      assign a_src[k]   = a;
      assign b_src[k]   = b;
      assign sum_src[k] = '0;
      assign c_src[k]   = cin;
    end else begin : g_next
      assign vld_src[k] = vld_q[k-1];
      assign a_src[k]   = a_q[k-1];
      assign b_src[k]   = b_q[k-1];
      assign sum_src[k] = sum_q[k-1];
      assign c_src[k]   = c_q[k-1];
    end

    rca_slice #(.SLICE(SLICE)) u_slice (
      .a     (a_src[k][k*SLICE +: SLICE]),
      .b     (b_src[k][k*SLICE +: SLICE]),
      .cin   (c_src[k]),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .c_msb (slice_cmsb)
    );

    always_comb begin
      merged                   = sum_src[k];
      merged[k*SLICE +: SLICE] = slice_sum;
    end

    assign sum_nxt[k] = merged;
    assign c_nxt[k]   = slice_cout;
    // Only the top slice's value reaches the ovf port.
    assign ovf_nxt[k] = slice_cmsb ^ slice_cout;
  end

  // NOTE: non-blocking assignments for all state so every stage samples the
  // previous stage's pre-edge value. Datapath registers are reset too, which
  // makes sum/cout/ovf read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        c_q[k]   <= 1'b0;
        ovf_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_src[k];
        // Bubbles leave data untouched, so the output holds the last result.
        if (vld_src[k]) begin
          a_q[k]   <= a_src[k];
          b_q[k]   <= b_src[k];
          sum_q[k] <= sum_nxt[k];
          c_q[k]   <= c_nxt[k];
          ovf_q[k] <= ovf_nxt[k];
        end
      end
    end
  end

endmodule
